// File: rtl/multdiv_wb_sched.sv
// ---------------------------------------------------------------------------
// multdiv_wb_sched
//
// Controller and write-port arbiter for the multiply/divide unit sitting in
// the memory/writeback stage. It issues mult/div start pulses from the
// execute stage and tracks the single outstanding operation and its
// destination register. It shares the one register-file write port between
// normal pipeline writeback and the multdiv result, buffering the result
// while the pipeline holds the port. It also produces issue and RAW/WAW
// stalls against the pending destination. Multdiv exceptions are redirected
// to rstatus (r30) with code 4 (mult) or 5 (div).
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   md_start/md_is_div/md_rd_in   op offered by execute (div when md_is_div)
//   md_ready/md_result/md_exception  one-cycle result pulse from multdiv
//   ctrl_mult, ctrl_div       one-cycle start pulses to multdiv
//   busy, issue_stall         op outstanding / execute must hold
//   dec_rs/dec_rt/dec_rd      decode-stage registers, hazard_stall out
//   pipe_we/pipe_rd/pipe_data pipeline writeback request, pipe_stall out
//   rf_we/rf_rd/rf_data       register-file write port
// ---------------------------------------------------------------------------
module multdiv_wb_sched #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic [4:0]  md_rd_in,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        busy,
    output logic        issue_stall,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic [4:0]  dec_rd,
    output logic        hazard_stall,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [4:0] RSTATUS = 5'd30;

    state_t      state_q, state_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_div_q, pend_div_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_exc_q, buf_exc_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    // Shared decode of the current cycle's request and result.
    logic        pipe_live;
    logic [4:0]  eff_rd;
    logic [31:0] eff_data;
    logic [4:0]  hold_rd;

    always_comb begin
        pipe_live = pipe_we & (pipe_rd != 5'd0);
        if (md_exception) begin
            eff_rd   = RSTATUS;
            eff_data = pend_div_q ? 32'd5 : 32'd4;
        end else begin
            eff_rd   = pend_rd_q;
            eff_data = md_result;
        end
        // The exception code is already folded into buf_data; only the
        // address needs redirecting when the held result is an exception.
        hold_rd = buf_exc_q ? RSTATUS : pend_rd_q;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pend_rd_q    <= 5'd0;
            pend_div_q   <= 1'b0;
            buf_data_q   <= 32'd0;
            buf_exc_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            pend_div_q   <= pend_div_d;
            buf_data_q   <= buf_data_d;
            buf_exc_q    <= buf_exc_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        pend_div_d   = pend_div_q;
        buf_data_d   = buf_data_q;
        buf_exc_d    = buf_exc_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    pend_rd_d  = md_rd_in;
                    pend_div_d = md_is_div;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (md_ready) begin
                    if ((eff_rd == 5'd0) || !pipe_live) begin
                        // Retired silently, or written straight through.
                        state_d = ST_IDLE;
                    end else begin
                        // Pipeline owns the port this cycle; park the result.
                        buf_data_d   = eff_data;
                        buf_exc_d    = md_exception;
                        starve_cnt_d = 4'd0;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!pipe_live) begin
                    state_d = ST_IDLE;
                end else if (starve_cnt_q < LIMIT) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    logic        md_we;
    logic [4:0]  md_wr_rd;
    logic [31:0] md_wr_data;
    logic        preempt;

    always_comb begin
        md_we        = 1'b0;
        md_wr_rd     = pend_rd_q;
        md_wr_data   = buf_data_q;
        preempt      = 1'b0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        busy         = 1'b0;
        issue_stall  = 1'b0;
        hazard_stall = 1'b0;
        pipe_stall   = 1'b0;
        rf_we        = 1'b0;
        rf_rd        = pipe_rd;
        rf_data      = pipe_data;

        unique case (state_q)
            ST_EXEC: begin
                if (md_ready && (eff_rd != 5'd0) && !pipe_live) begin
                    md_we      = 1'b1;
                    md_wr_rd   = eff_rd;
                    md_wr_data = eff_data;
                end
            end
            ST_HOLD: begin
                md_wr_rd   = hold_rd;
                md_wr_data = buf_data_q;
                if (!pipe_live) begin
                    md_we = 1'b1;
                end else if (starve_cnt_q >= LIMIT) begin
                    md_we   = 1'b1;
                    preempt = 1'b1;
                end
            end
            default: ;
        endcase

        // Reset silences every output combinationally, including the
        // pipeline pass-through path that does not depend on state.
        if (!reset) begin
            busy         = (state_q != ST_IDLE);
            ctrl_mult    = (state_q == ST_IDLE) & md_start & ~md_is_div;
            ctrl_div     = (state_q == ST_IDLE) & md_start & md_is_div;
            issue_stall  = md_start & busy;
            hazard_stall = busy & (pend_rd_q != 5'd0) &
                           ((dec_rs == pend_rd_q) | (dec_rt == pend_rd_q) |
                            (dec_rd == pend_rd_q));
            pipe_stall   = preempt;
            rf_we        = md_we | (pipe_live & ~preempt);
            if (md_we) begin
                rf_rd   = md_wr_rd;
                rf_data = md_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_wb_sched.sv
module tb_multdiv_wb_sched;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        md_start, md_is_div, md_ready, md_exception;
    logic [4:0]  md_rd_in;
    logic [31:0] md_result;
    logic        ctrl_mult, ctrl_div, busy, issue_stall, hazard_stall;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic        pipe_we, pipe_stall, rf_we;
    logic [4:0]  pipe_rd, rf_rd;
    logic [31:0] pipe_data, rf_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multdiv_wb_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .md_start(md_start), .md_is_div(md_is_div), .md_rd_in(md_rd_in),
        .md_ready(md_ready), .md_result(md_result), .md_exception(md_exception),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .busy(busy),
        .issue_stall(issue_stall),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .hazard_stall(hazard_stall),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    // ---------------- behavioural model ----------------
    // An operation is either absent, in flight (waiting for its result) or
    // parked (result captured, waiting for the port).
    bit          m_inflight, m_parked;
    logic [4:0]  m_dst;
    bit          m_div;
    logic [4:0]  m_park_rd;
    logic [31:0] m_park_data;
    int          m_losses;

    bit          n_inflight, n_parked;
    logic [4:0]  n_dst;
    bit          n_div;
    logic [4:0]  n_park_rd;
    logic [31:0] n_park_data;
    int          n_losses;

    logic        e_cm, e_cd, e_busy, e_issue, e_haz, e_pstall, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Work out what this cycle must look like from the current inputs and
    // the model, compare it with the DUT, and stage the model's next value.
    task automatic check_cycle();
        bit          live, occupied, md_w;
        logic [4:0]  w_rd, tgt_rd;
        logic [31:0] w_data, tgt_data;

        {e_cm, e_cd, e_busy, e_issue, e_haz, e_pstall, e_we} = '0;
        e_rd = '0;
        e_data = '0;
        n_inflight = m_inflight; n_parked = m_parked; n_dst = m_dst; n_div = m_div;
        n_park_rd = m_park_rd; n_park_data = m_park_data; n_losses = m_losses;

        if (reset) begin
            n_inflight = 0; n_parked = 0; n_dst = '0; n_div = 0;
            n_park_rd = '0; n_park_data = '0; n_losses = 0;
        end else begin
            live     = pipe_we && (pipe_rd != 0);
            occupied = m_inflight || m_parked;
            md_w     = 0;
            w_rd     = '0;
            w_data   = '0;
            e_busy   = occupied;
            e_issue  = md_start && occupied;
            e_cm     = md_start && !occupied && !md_is_div;
            e_cd     = md_start && !occupied && md_is_div;
            e_haz    = occupied && (m_dst != 0) &&
                       (dec_rs == m_dst || dec_rt == m_dst || dec_rd == m_dst);
            if (md_start && !occupied) begin
                n_inflight = 1; n_dst = md_rd_in; n_div = md_is_div;
            end
            if (m_inflight && md_ready) begin
                tgt_rd   = md_exception ? 5'd30 : m_dst;
                tgt_data = md_exception ? (m_div ? 32'd5 : 32'd4) : md_result;
                n_inflight = 0;
                if (tgt_rd == 0) begin
                    // discarded
                end else if (!live) begin
                    md_w = 1; w_rd = tgt_rd; w_data = tgt_data;
                end else begin
                    n_parked = 1; n_park_rd = tgt_rd; n_park_data = tgt_data; n_losses = 0;
                end
            end
            if (m_parked) begin
                if (!live || m_losses == LIMIT) begin
                    md_w = 1; w_rd = m_park_rd; w_data = m_park_data;
                    e_pstall = live;
                    n_parked = 0;
                end else begin
                    n_losses = m_losses + 1;
                end
            end
            e_we   = md_w || (live && !e_pstall);
            e_rd   = md_w ? w_rd : pipe_rd;
            e_data = md_w ? w_data : pipe_data;
        end

        chk("ctrl_mult", 32'(ctrl_mult), 32'(e_cm));
        chk("ctrl_div", 32'(ctrl_div), 32'(e_cd));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("issue_stall", 32'(issue_stall), 32'(e_issue));
        chk("hazard_stall", 32'(hazard_stall), 32'(e_haz));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_pstall));
        chk("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_rd", 32'(rf_rd), 32'(e_rd));
            chk("rf_data", rf_data, e_data);
        end
    endtask

    task automatic cyc();
        #4;
        check_cycle();
    endtask

    task automatic tick();
        @(posedge clock);
        m_inflight = n_inflight; m_parked = n_parked; m_dst = n_dst; m_div = n_div;
        m_park_rd = n_park_rd; m_park_data = n_park_data; m_losses = n_losses;
        #1;
    endtask

    task automatic quiet();
        md_start = 0; md_is_div = 0; md_rd_in = 0; md_ready = 0;
        md_result = 0; md_exception = 0;
        dec_rs = 0; dec_rt = 0; dec_rd = 0;
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    endtask

    task automatic start_op(input bit is_div, input logic [4:0] rd);
        quiet();
        md_start = 1; md_is_div = is_div; md_rd_in = rd;
        cyc(); tick();
        quiet();
    endtask

    initial begin
        m_inflight = 0; m_parked = 0; m_dst = 0; m_div = 0;
        m_park_rd = 0; m_park_data = 0; m_losses = 0;
        quiet();
        reset = 1;
        @(posedge clock); #1;
        pipe_we = 1; pipe_rd = 5'd4; md_start = 1;
        cyc();
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_ctrl_mult", 32'(ctrl_mult), 32'd0);
        tick();
        reset = 0;
        quiet();
        cyc(); tick();

        // Mult with a free port: written straight through on md_ready.
        quiet(); md_start = 1; md_is_div = 0; md_rd_in = 5'd5;
        cyc();
        chk("t1_ctrl_mult", 32'(ctrl_mult), 32'd1);
        tick(); quiet();
        cyc(); tick();
        cyc(); tick();
        md_ready = 1; md_result = 32'h2A;
        cyc();
        chk("t1_rf_we", 32'(rf_we), 32'd1);
        chk("t1_rf_rd", 32'(rf_rd), 32'd5);
        chk("t1_rf_data", rf_data, 32'h2A);
        tick(); quiet();
        cyc();
        chk("t1_busy_drop", 32'(busy), 32'd0);
        tick();

        // Contention: pipeline wins, result written on the next free cycle.
        start_op(0, 5'd11);
        md_ready = 1; md_result = 32'h77; pipe_we = 1; pipe_rd = 5'd7; pipe_data = 32'h1234;
        cyc();
        chk("t2_pipe_rd", 32'(rf_rd), 32'd7);
        tick(); quiet();
        cyc();
        chk("t2_held_rd", 32'(rf_rd), 32'd11);
        chk("t2_held_data", rf_data, 32'h77);
        tick();

        // Starvation: four pipeline wins in HOLD, then one preemption.
        start_op(0, 5'd13);
        md_ready = 1; md_result = 32'hBEEF; pipe_we = 1; pipe_rd = 5'd3; pipe_data = 32'h33;
        cyc(); tick();
        md_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_pipe_wins", 32'(pipe_stall), 32'd0);
            tick();
        end
        cyc();
        chk("t3_preempt", 32'(pipe_stall), 32'd1);
        chk("t3_preempt_rd", 32'(rf_rd), 32'd13);
        tick();
        cyc();
        chk("t3_resume_rd", 32'(rf_rd), 32'd3);
        tick();

        // Divide exception lands in rstatus with code 5.
        start_op(1, 5'd9);
        md_ready = 1; md_exception = 1; md_result = 32'hDEAD;
        cyc();
        chk("t4_rd", 32'(rf_rd), 32'd30);
        chk("t4_data", rf_data, 32'd5);
        tick(); quiet();

        // Hazards, issue stall, silent retire to r0.
        start_op(0, 5'd12);
        dec_rs = 5'd12;
        cyc();
        chk("t5_hazard", 32'(hazard_stall), 32'd1);
        tick();
        md_start = 1; md_is_div = 1;
        cyc();
        chk("t5_issue_stall", 32'(issue_stall), 32'd1);
        chk("t5_no_div", 32'(ctrl_div), 32'd0);
        tick(); quiet();
        md_ready = 1; md_result = 32'h1;
        cyc(); tick(); quiet();
        start_op(0, 5'd0);
        cyc();
        chk("t5_r0_hazard", 32'(hazard_stall), 32'd0);
        tick();
        md_ready = 1; md_result = 32'h99;
        cyc();
        chk("t5_r0_no_write", 32'(rf_we), 32'd0);
        tick(); quiet();

        // Reset while a result is held.
        start_op(0, 5'd14);
        md_ready = 1; md_result = 32'h55; pipe_we = 1; pipe_rd = 5'd3;
        cyc(); tick();
        md_ready = 0;
        cyc();
        #1 reset = 1;
        #1;
        check_cycle();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rf_we", 32'(rf_we), 32'd0);
        tick();
        reset = 0;
        quiet();
        for (int i = 0; i < 3; i++) begin
            md_ready = 1;
            cyc();
            chk("t6_no_stale", 32'(rf_we), 32'd0);
            tick();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            md_start     = ($urandom_range(0, 9) < 3);
            md_is_div    = 1'($urandom);
            md_rd_in     = 5'($urandom);
            md_ready     = ($urandom_range(0, 3) == 0);
            md_exception = ($urandom_range(0, 4) == 0);
            md_result    = $urandom;
            dec_rs       = 5'($urandom_range(0, 15));
            dec_rt       = 5'($urandom_range(0, 15));
            dec_rd       = 5'($urandom_range(0, 15));
            pipe_we      = ($urandom_range(0, 9) < 8);
            pipe_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_data    = $urandom;
            cyc(); tick();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
